// File: rtl/approx_mul_err_sweep.sv
// approx_mul_err_sweep: drives every W x W operand pair into an external
// combinational approximate multiplier and accumulates error statistics
// against an internally computed exact product.
//
// Ports:
//   clk_i, rst_i     clock (rising edge) and synchronous active-high reset
//   start_i          one-cycle pulse, begins a sweep from IDLE or DONE
//   abort_i          one-cycle pulse, cancels a running sweep
//   op_a_o, op_b_o   registered operands to the multiplier under test
//   approx_p_i       product returned for op_a_o/op_b_o in the same cycle
//   busy_o           high while sweeping or draining the pipeline
//   done_o           high once results are final, until next start or reset
//   err_count_o      number of pairs with a wrong product
//   sum_abs_err_o    sum of |approx - exact|
//   max_abs_err_o    largest |approx - exact|
//   worst_a_o/_b_o   operands of the first pair that reached max_abs_err_o
module approx_mul_err_sweep #(
  parameter int unsigned W     = 6,
  parameter int unsigned CNT_W = 2 * W + 1,
  parameter int unsigned SUM_W = 4 * W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  output logic [W-1:0]     op_a_o,
  output logic [W-1:0]     op_b_o,
  input  logic [2*W-1:0]   approx_p_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [SUM_W-1:0] sum_abs_err_o,
  output logic [2*W-1:0]   max_abs_err_o,
  output logic [W-1:0]     worst_a_o,
  output logic [W-1:0]     worst_b_o
);

  localparam int unsigned P = 2 * W;

  typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  // {op_a, op_b}; op_b is the fast-changing half
  logic [P-1:0]     idx_q, idx_d;
  // Stage-1 validity is implied by StSweep; stage 2 needs its own flag.
  logic             smp_vld_q, smp_vld_d;
  logic [P-1:0]     approx_q, approx_d;
  logic [P-1:0]     exact_q, exact_d;
  logic [W-1:0]     smp_a_q, smp_a_d;
  logic [W-1:0]     smp_b_q, smp_b_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [P-1:0]     max_q, max_d;
  logic [W-1:0]     worst_a_q, worst_a_d;
  logic [W-1:0]     worst_b_q, worst_b_d;

  logic [P-1:0]     abs_err;
  logic             busy;

  assign busy    = (state_q == StSweep) || (state_q == StDrain);
  assign abs_err = (approx_q >= exact_q) ? (approx_q - exact_q) : (exact_q - approx_q);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    smp_vld_d = smp_vld_q;
    approx_d  = approx_q;
    exact_d   = exact_q;
    smp_a_d   = smp_a_q;
    smp_b_d   = smp_b_q;
    err_cnt_d = err_cnt_q;
    sum_d     = sum_q;
    max_d     = max_q;
    worst_a_d = worst_a_q;
    worst_b_d = worst_b_q;

    // An abort edge folds nothing; the pending sample is discarded.
    if (smp_vld_q && !(busy && abort_i)) begin
      if (abs_err != '0) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
      sum_d = sum_q + SUM_W'(abs_err);
      // Strict compare keeps the first pair in sweep order on ties.
      if (abs_err > max_q) begin
        max_d     = abs_err;
        worst_a_d = smp_a_q;
        worst_b_d = smp_b_q;
      end
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d   = StSweep;
          idx_d     = '0;
          smp_vld_d = 1'b0;
          err_cnt_d = '0;
          sum_d     = '0;
          max_d     = '0;
          worst_a_d = '0;
          worst_b_d = '0;
        end
      end
      StSweep: begin
        if (abort_i) begin
          state_d   = StIdle;
          smp_vld_d = 1'b0;
        end else begin
          approx_d  = approx_p_i;
          exact_d   = P'(idx_q[P-1:W]) * P'(idx_q[W-1:0]);
          smp_a_d   = idx_q[P-1:W];
          smp_b_d   = idx_q[W-1:0];
          smp_vld_d = 1'b1;
          if (idx_q == '1) begin
            state_d = StDrain;    // operands hold the last pair
          end else begin
            idx_d = idx_q + P'(1);
          end
        end
      end
      StDrain: begin
        smp_vld_d = 1'b0;
        state_d   = abort_i ? StIdle : StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      smp_vld_q <= 1'b0;
      approx_q  <= '0;
      exact_q   <= '0;
      smp_a_q   <= '0;
      smp_b_q   <= '0;
      err_cnt_q <= '0;
      sum_q     <= '0;
      max_q     <= '0;
      worst_a_q <= '0;
      worst_b_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      smp_vld_q <= smp_vld_d;
      approx_q  <= approx_d;
      exact_q   <= exact_d;
      smp_a_q   <= smp_a_d;
      smp_b_q   <= smp_b_d;
      err_cnt_q <= err_cnt_d;
      sum_q     <= sum_d;
      max_q     <= max_d;
      worst_a_q <= worst_a_d;
      worst_b_q <= worst_b_d;
    end
  end

  assign op_a_o        = idx_q[P-1:W];
  assign op_b_o        = idx_q[W-1:0];
  assign busy_o        = busy;
  assign done_o        = (state_q == StDone);
  assign err_count_o   = err_cnt_q;
  assign sum_abs_err_o = sum_q;
  assign max_abs_err_o = max_q;
  assign worst_a_o     = worst_a_q;
  assign worst_b_o     = worst_b_q;

endmodule
